// File: rtl/serial_debug_fmt_pkg.sv
// Shared state encoding, ASCII constants and helpers for serial_debug_fmt.
// SERIAL_DEBUG_FMT_HEX_EN switches frame_bytes to the hex field layout.
package serial_debug_fmt_pkg;

   typedef enum logic [1:0] {S_IDLE, S_CONV, S_SEND, S_WAIT} state_t;

   localparam logic [7:0] A_C     = 8'h43;
   localparam logic [7:0] A_COLON = 8'h3A;
   localparam logic [7:0] A_SP    = 8'h20;
   localparam logic [7:0] A_CR    = 8'h0D;
   localparam logic [7:0] A_LF    = 8'h0A;
   localparam logic [7:0] A_0     = 8'h30;
   localparam logic [7:0] A_A     = 8'h41;
   localparam logic [7:0] A_X     = 8'h78;

`ifdef SERIAL_DEBUG_FMT_HEX_EN
   localparam bit HEX_EN = 1'b1;
`else
   localparam bit HEX_EN = 1'b0;
`endif

   function automatic int frame_bytes(input int n_ch, input int width, input int digits);
      int dec_len;
      int hex_len;
      dec_len = n_ch * (4 + digits) + 1;
      hex_len = n_ch * (6 + (width + 3) / 4) + 1;
      frame_bytes = HEX_EN ? hex_len : dec_len;
   endfunction

   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      hex_ascii = (nib < 4'd10) ? (A_0 + {4'h0, nib}) : (A_A + {4'h0, nib} - 8'd10);
   endfunction

endpackage

// File: rtl/serial_debug_fmt_bin2bcd.sv
// Sequential double-dabble: i_start loads i_bin, result valid after exactly WIDTH cycles.
// o_done is high in the cycle whose closing edge completes the conversion; no backpressure.
module bin2bcd_seq #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic [WIDTH-1:0]      i_bin,
   output logic [4*DIGITS-1:0]   o_bcd,
   output logic                  o_done
);
   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0]    r_bin;
   logic [4*DIGITS-1:0] r_bcd;
   logic [4*DIGITS-1:0] w_adj;
   logic [CW-1:0]       r_cnt;

   always_comb begin
      w_adj = r_bcd;
      for (int d = 0; d < DIGITS; d++) begin
         if (r_bcd[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bin <= '0;
         r_bcd <= '0;
         r_cnt <= '0;
      end else if (i_start) begin
         r_bin <= i_bin;
         r_bcd <= '0;
         r_cnt <= CW'(WIDTH);
      end else if (r_cnt != '0) begin
         // top digit never carries out because 10^DIGITS exceeds the input range
         r_bcd <= (w_adj << 1) | {{(4*DIGITS-1){1'b0}}, r_bin[WIDTH-1]};
         r_bin <= r_bin << 1;
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_bcd  = r_bcd;
   assign o_done = (r_cnt == CW'(1));
endmodule

// File: rtl/serial_debug_fmt.sv
// Snapshots N_CH values on a send edge and streams "Ci:<field> ... \r\n" bytes; first byte WIDTH+1 cycles after trigger (1 with SERIAL_DEBUG_FMT_HEX_EN).
// Bytes wait for tx_busy low with at least 2-cycle spacing; triggers while busy or blocked pulse overrun.
module serial_debug_fmt
   import serial_debug_fmt_pkg::*;
#(
   parameter int N_CH   = 4,
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    send,
   input  logic                    block,
   input  logic [N_CH*WIDTH-1:0]   vals,
   input  logic                    tx_busy,
   output logic [7:0]              tx_data,
   output logic                    tx_new_data,
   output logic                    busy,
   output logic                    overrun
);
   localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [CHW-1:0] LAST_CH = CHW'(N_CH - 1);
`ifdef SERIAL_DEBUG_FMT_HEX_EN
   localparam int HX = (WIDTH + 3) / 4;
   localparam logic [5:0] P_SEP = 6'(5 + HX);
   localparam state_t S_FIELD = S_SEND;
`else
   localparam logic [5:0] P_SEP = 6'(3 + DIGITS);
   localparam state_t S_FIELD = S_CONV;
`endif

   state_t           r_state;
   logic             r_send_q;
   logic [CHW-1:0]   r_ch;
   logic [5:0]       r_pos;
   logic             r_eoc;
   logic [WIDTH-1:0] r_snap [N_CH];
   logic             w_edge;
   logic             w_accept;
   logic [5:0]       w_end;
   logic [5:0]       w_didx;
   logic [7:0]       w_byte;

   assign w_edge   = send & ~r_send_q;
   assign w_accept = w_edge & (r_state == S_IDLE) & ~block;
   assign w_end    = (r_ch == LAST_CH) ? (P_SEP + 6'd1) : P_SEP;

`ifdef SERIAL_DEBUG_FMT_HEX_EN
   logic [4*HX-1:0] w_hv;
   always_comb begin
      w_hv = '0;
      w_hv[WIDTH-1:0] = r_snap[r_ch];
   end
`else
   logic                w_start;
   logic                w_done;
   logic [CHW-1:0]      w_nch;
   logic [WIDTH-1:0]    w_cbin;
   logic [4*DIGITS-1:0] w_bcd;

   // channel 0 converts straight from vals so CONV can start on the accept edge
   assign w_nch   = r_ch + 1'b1;
   assign w_cbin  = (r_state == S_IDLE) ? vals[WIDTH-1:0] : r_snap[w_nch];
   assign w_start = w_accept | ((r_state == S_WAIT) & ~tx_busy & r_eoc & (r_ch != LAST_CH));

   bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_bcd (
      .clk     (clk),
      .rst     (rst),
      .i_start (w_start),
      .i_bin   (w_cbin),
      .o_bcd   (w_bcd),
      .o_done  (w_done)
   );
`endif

   always_comb begin
      w_byte = A_LF;
      w_didx = P_SEP - 6'd1 - r_pos;
      if (r_pos == 6'd0)      w_byte = A_C;
      else if (r_pos == 6'd1) w_byte = hex_ascii(4'(r_ch));
      else if (r_pos == 6'd2) w_byte = A_COLON;
`ifdef SERIAL_DEBUG_FMT_HEX_EN
      else if (r_pos == 6'd3) w_byte = A_0;
      else if (r_pos == 6'd4) w_byte = A_X;
      else if (r_pos < P_SEP) w_byte = hex_ascii(w_hv[w_didx*4 +: 4]);
`else
      else if (r_pos < P_SEP) w_byte = A_0 + {4'h0, w_bcd[w_didx*4 +: 4]};
`endif
      else if (r_pos == P_SEP) w_byte = (r_ch == LAST_CH) ? A_CR : A_SP;
   end

   always_ff @(posedge clk) begin
      if (!rst && w_accept) begin
         for (int i = 0; i < N_CH; i++) r_snap[i] <= vals[i*WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_send_q    <= 1'b0;
         r_ch        <= '0;
         r_pos       <= '0;
         r_eoc       <= 1'b0;
         tx_data     <= '0;
         tx_new_data <= 1'b0;
         busy        <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         r_send_q    <= send;
         tx_new_data <= 1'b0;
         overrun     <= w_edge & ~w_accept;
         case (r_state)
            S_IDLE: if (w_accept) begin
               r_ch    <= '0;
               r_pos   <= '0;
               busy    <= 1'b1;
               r_state <= S_FIELD;
            end
`ifndef SERIAL_DEBUG_FMT_HEX_EN
            S_CONV: if (w_done) r_state <= S_SEND;
`endif
            S_SEND: if (!tx_busy && !tx_new_data) begin
               tx_data     <= w_byte;
               tx_new_data <= 1'b1;
               r_eoc       <= (r_pos == w_end);
               r_pos       <= (r_pos == w_end) ? 6'd0 : r_pos + 6'd1;
               r_state     <= S_WAIT;
            end
            S_WAIT: if (!tx_busy) begin
               if (!r_eoc) begin
                  r_state <= S_SEND;
               end else if (r_ch == LAST_CH) begin
                  busy    <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_ch    <= r_ch + 1'b1;
                  r_state <= S_FIELD;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_debug_fmt.sv
// Bench for serial_debug_fmt (N_CH=2, WIDTH=16, DIGITS=5); honours SERIAL_DEBUG_FMT_HEX_EN.
module tb_serial_debug_fmt;
   localparam int N_CH = 2, WIDTH = 16, DIGITS = 5;
   localparam int VW = N_CH * WIDTH;
`ifdef SERIAL_DEBUG_FMT_HEX_EN
   localparam int FB  = N_CH * (6 + (WIDTH + 3) / 4) + 1;
   localparam int LAT = 2;
`else
   localparam int FB  = N_CH * (4 + DIGITS) + 1;
   localparam int LAT = WIDTH + 2;
`endif
   typedef logic [8*FB-1:0] frame_t;
   typedef struct { logic [VW-1:0] vv; frame_t exp; } vec_t;

   logic clk = 1'b0, rst = 1'b1, send = 1'b0, block = 1'b0, tx_busy = 1'b0;
   logic [VW-1:0] vals = '0;
   logic [7:0] tx_data;
   logic tx_new_data, busy, overrun;

   serial_debug_fmt #(.N_CH(N_CH), .WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clk(clk), .rst(rst), .send(send), .block(block), .vals(vals), .tx_busy(tx_busy),
      .tx_data(tx_data), .tx_new_data(tx_new_data), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int n_chk = 0, n_err = 0;
   int first_cyc = -1, last_cyc = 0, fall_cyc = 0, tsend = 0;
   int n_ovr = 0, n_bp_viol = 0, n_space_viol = 0;
   bit bsy_at_edge = 1'b0, prev_strobe = 1'b0, bp_en = 1'b0, busy_hi = 1'b0;
   logic [7:0] rx_q[$];
   vec_t tbl[4];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      bsy_at_edge = tx_busy;
   end

   always @(negedge clk) begin
      if (tx_new_data) begin
         if (rx_q.size() == 0) first_cyc = cyc;
         last_cyc = cyc;
         rx_q.push_back(tx_data);
         if (bsy_at_edge) n_bp_viol++;
         if (prev_strobe) n_space_viol++;
      end
      prev_strobe = tx_new_data;
      if (overrun) n_ovr++;
   end

   // transmitter model: raises busy one cycle after a strobe and holds it 100 cycles
   initial forever begin
      @(negedge clk);
      if (bp_en && tx_new_data) begin
         @(negedge clk);
         tx_busy = 1'b1;
         repeat (100) @(negedge clk);
         tx_busy = 1'b0;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1);
   end

   function automatic frame_t model(input logic [VW-1:0] vv);
      string hx = "0123456789ABCDEF";
      logic [7:0] b[$];
      frame_t f;
      longint v, p;
      for (int c = 0; c < N_CH; c++) begin
         v = longint'(vv[c*WIDTH +: WIDTH]);
         b.push_back(8'h43); b.push_back(hx[c]); b.push_back(8'h3A);
`ifdef SERIAL_DEBUG_FMT_HEX_EN
         b.push_back(8'h30); b.push_back(8'h78);
         for (int k = (WIDTH + 3) / 4 - 1; k >= 0; k--) b.push_back(hx[int'((v >> (4*k)) % 16)]);
`else
         p = 1;
         repeat (DIGITS - 1) p = p * 10;
         for (int k = 0; k < DIGITS; k++) begin
            b.push_back(8'h30 + 8'((v / p) % 10));
            p = p / 10;
         end
`endif
         if (c == N_CH - 1) begin b.push_back(8'h0D); b.push_back(8'h0A); end
         else b.push_back(8'h20);
      end
      f = '0;
      for (int i = 0; i < FB; i++) f[8*(FB-1-i) +: 8] = b[i];
      return f;
   endfunction

   function automatic string pstr(input frame_t f);
      string s = "";
      logic [7:0] ch;
      for (int i = 0; i < FB; i++) begin
         ch = f[8*(FB-1-i) +: 8];
         s = {s, (ch < 8'h20 || ch > 8'h7E) ? "." : $sformatf("%c", ch)};
      end
      return s;
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
      end
   endtask

   task automatic chk_frame(input string nm, input frame_t exp);
      frame_t got = '0;
      n_chk++;
      for (int i = 0; i < rx_q.size() && i < FB; i++) got[8*(FB-1-i) +: 8] = rx_q[i];
      if (rx_q.size() != FB || got !== exp) begin
         n_err++;
         $display("FAIL %s: got \"%s\" (%0d bytes), expected \"%s\" (%0d bytes)",
                  nm, pstr(got), rx_q.size(), pstr(exp), FB);
      end
   endtask

   task automatic start_frame(input logic [VW-1:0] vv);
      rx_q.delete();
      first_cyc = -1;
      vals = vv;
      send = 1'b1;
      tsend = cyc;
      @(negedge clk);
      send = 1'b0;
      busy_hi = busy;
   endtask

   task automatic pulse_send();
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_frame(input bit scramble);
      int n = 0;
      while (rx_q.size() < FB && n < 5000) begin
         if (scramble) vals = VW'({$urandom, $urandom});
         @(negedge clk);
         n++;
      end
      n = 0;
      while (busy && n < 500) begin @(negedge clk); n++; end
      fall_cyc = cyc;
   endtask

   task automatic wait_bytes(input int cnt);
      int n = 0;
      while (rx_q.size() < cnt && n < 5000) begin @(negedge clk); n++; end
   endtask

   initial begin
      logic [VW-1:0] vv;
      int held;
`ifdef SERIAL_DEBUG_FMT_HEX_EN
      tbl[0] = '{{16'd0,     16'd456},   "C0:0x01C8 C1:0x0000\r\n"};
      tbl[1] = '{{16'hFFFF,  16'h0000},  "C0:0x0000 C1:0xFFFF\r\n"};
      tbl[2] = '{{16'h1234,  16'hABCD},  "C0:0xABCD C1:0x1234\r\n"};
      tbl[3] = '{{16'd10,    16'd9},     "C0:0x0009 C1:0x000A\r\n"};
`else
      tbl[0] = '{{16'd65535, 16'd456},   "C0:00456 C1:65535\r\n"};
      tbl[1] = '{{16'd0,     16'd0},     "C0:00000 C1:00000\r\n"};
      tbl[2] = '{{16'd1,     16'd65535}, "C0:65535 C1:00001\r\n"};
      tbl[3] = '{{16'd10000, 16'd9999},  "C0:09999 C1:10000\r\n"};
`endif
      repeat (3) @(negedge clk);
      chk("reset_tx_data", tx_data, 0);
      chk("reset_tx_new_data", tx_new_data, 0);
      chk("reset_busy", busy, 0);
      chk("reset_overrun", overrun, 0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         start_frame(tbl[i].vv);
         wait_frame(1'b0);
         chk_frame($sformatf("table%0d_frame", i), tbl[i].exp);
         chk($sformatf("table%0d_first_strobe_latency", i), first_cyc - tsend, LAT);
         chk($sformatf("table%0d_busy_after_trigger", i), busy_hi, 1);
         chk($sformatf("table%0d_busy_fall", i), fall_cyc - last_cyc, 1);
      end

      // random values, alternate frames scramble vals after the trigger edge
      for (int i = 0; i < 6; i++) begin
         vv = VW'({$urandom, $urandom});
         if (i == 4) vv[WIDTH-1:0] = '1;
         start_frame(vv);
         wait_frame(i[0]);
         chk_frame($sformatf("random%0d_frame", i), model(vv));
      end

      bp_en = 1'b1;
      vv = VW'({$urandom, $urandom});
      start_frame(vv);
      wait_frame(1'b0);
      chk_frame("backpressure_frame", model(vv));
      bp_en = 1'b0;
      held = 0;
      while (tx_busy && held < 200) begin @(negedge clk); held++; end

      n_ovr = 0;
      vv = VW'({$urandom, $urandom});
      start_frame(vv);
      wait_bytes(5);
      pulse_send();
      wait_frame(1'b0);
      chk_frame("overrun_frame_intact", model(vv));
      block = 1'b1;
      pulse_send();
      block = 1'b0;
      repeat (40) @(negedge clk);
      chk("overrun_no_second_frame", rx_q.size(), FB);
      chk("overrun_pulse_cycles", n_ovr, 2);
      chk("overrun_idle_busy", busy, 0);

      vv = VW'({$urandom, $urandom});
      start_frame(vv);
      wait_bytes(7);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midreset_tx_data", tx_data, 0);
      chk("midreset_tx_new_data", tx_new_data, 0);
      chk("midreset_busy", busy, 0);
      chk("midreset_overrun", overrun, 0);
      held = rx_q.size();
      repeat (60) @(negedge clk);
      chk("midreset_no_more_strobes", rx_q.size(), held);
      vv = VW'({$urandom, $urandom});
      start_frame(vv);
      wait_frame(1'b0);
      chk_frame("after_reset_frame", model(vv));

      rx_q.delete();
      rst = 1'b1;
      send = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      send = 1'b0;
      repeat (30) @(negedge clk);
      chk("send_with_reset_busy", busy, 0);
      chk("send_with_reset_no_bytes", rx_q.size(), 0);

      chk("strobe_while_tx_busy", n_bp_viol, 0);
      chk("back_to_back_strobes", n_space_viol, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
